// File: rtl/commit_eng_pipe.sv
// Pipelined commit engine: walks log entries up to the commit target, setting each entry's committed bit
// with several reads in flight, then publishes the new commit number. Optional macro: COMMIT_ENG_VIEW_CHECK_EN.
module commit_eng_pipe #(
  parameter int OP_NUM_W        = 64,
  parameter int LOG_DEPTH_LOG2  = 10,
  parameter int ENTRY_W         = 128,
  parameter int MAX_OUTSTANDING = 4,
  parameter int VIEW_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      msg_val,
  output logic                      msg_rdy,
  input  logic [VIEW_W-1:0]         msg_view,
  input  logic [OP_NUM_W-1:0]       msg_commit_num,
  input  logic [VIEW_W-1:0]         state_view,
  input  logic [OP_NUM_W-1:0]       state_commit_num,
  input  logic [OP_NUM_W-1:0]       state_last_op,
  output logic                      state_wr_val,
  input  logic                      state_wr_rdy,
  output logic [OP_NUM_W-1:0]       state_wr_commit_num,
  output logic                      rd_req_val,
  input  logic                      rd_req_rdy,
  output logic [LOG_DEPTH_LOG2-1:0] rd_req_addr,
  input  logic                      rd_resp_val,
  output logic                      rd_resp_rdy,
  input  logic [ENTRY_W-1:0]        rd_resp_data,
  output logic                      wr_val,
  input  logic                      wr_rdy,
  output logic [LOG_DEPTH_LOG2-1:0] wr_addr,
  output logic [ENTRY_W-1:0]        wr_data,
  output logic                      commit_eng_rdy,
  output logic                      drop_pulse
);

  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, UPDATE_STATE} state_t;

  localparam logic [3:0]         MAX_O       = 4'(MAX_OUTSTANDING);
  localparam logic [ENTRY_W-1:0] COMMIT_MASK = {2'b01, {(ENTRY_W-2){1'b0}}};

  state_t              state_reg, state_next;
  logic [OP_NUM_W-1:0] msg_commit_reg, target_reg, rd_op_reg, wr_op_reg, done_op_reg;
  logic [3:0]          outst_reg, outst_next;
  logic [OP_NUM_W-1:0] target_calc;
  logic                view_drop, resp_ok, resp_pend, req_fire, resp_fire, good_fire;
  logic                in_run, in_drain;

`ifdef COMMIT_ENG_VIEW_CHECK_EN
  logic [VIEW_W-1:0] msg_view_reg;
  assign view_drop = (msg_view_reg != state_view);
`else
  logic unused_view;
  assign view_drop   = 1'b0;
  assign unused_view = ^{msg_view, state_view};
`endif

  assign target_calc = (msg_commit_reg < state_last_op) ? msg_commit_reg : state_last_op;
  assign in_run      = (state_reg == RUN);
  assign in_drain    = (state_reg == DRAIN);
  assign resp_pend   = (outst_reg != 4'd0);
  assign resp_ok     = rd_resp_data[ENTRY_W-1] && (rd_resp_data[OP_NUM_W-1:0] == wr_op_reg);

  assign rd_req_val  = in_run && (rd_op_reg <= target_reg) && (outst_reg < MAX_O);
  assign rd_req_addr = rd_req_val ? rd_op_reg[LOG_DEPTH_LOG2-1:0] : '0;

  // A good response is only taken when the write can go out in the same cycle.
  assign wr_val      = in_run && resp_pend && rd_resp_val && resp_ok;
  assign wr_addr     = wr_val ? wr_op_reg[LOG_DEPTH_LOG2-1:0] : '0;
  assign wr_data     = wr_val ? (rd_resp_data | COMMIT_MASK) : '0;
  assign rd_resp_rdy = resp_pend && ((in_run && (resp_ok ? wr_rdy : 1'b1)) || in_drain);

  assign req_fire    = rd_req_val && rd_req_rdy;
  assign resp_fire   = rd_resp_val && rd_resp_rdy;
  assign good_fire   = resp_fire && resp_ok && in_run;
  assign outst_next  = outst_reg + {3'd0, req_fire} - {3'd0, resp_fire};

  always_comb begin
    state_next          = state_reg;
    msg_rdy             = 1'b0;
    commit_eng_rdy      = 1'b0;
    drop_pulse          = 1'b0;
    state_wr_val        = 1'b0;
    state_wr_commit_num = '0;
    case (state_reg)
      IDLE: begin
        msg_rdy        = 1'b1;
        commit_eng_rdy = 1'b1;
        if (msg_val) state_next = CHECK;
      end
      CHECK: begin
        if (view_drop || (target_calc <= state_commit_num)) begin
          drop_pulse = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (resp_fire && !resp_ok)
          state_next = DRAIN;
        else if ((rd_op_reg > target_reg) && !resp_pend)
          state_next = UPDATE_STATE;
      end
      DRAIN: begin
        if (!resp_pend)
          state_next = (done_op_reg > state_commit_num) ? UPDATE_STATE : IDLE;
      end
      UPDATE_STATE: begin
        state_wr_val        = 1'b1;
        state_wr_commit_num = done_op_reg;
        if (state_wr_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      outst_reg      <= 4'd0;
      msg_commit_reg <= '0;
      target_reg     <= '0;
      rd_op_reg      <= '0;
      wr_op_reg      <= '0;
      done_op_reg    <= '0;
`ifdef COMMIT_ENG_VIEW_CHECK_EN
      msg_view_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      outst_reg <= outst_next;
      if ((state_reg == IDLE) && msg_val) begin
        msg_commit_reg <= msg_commit_num;
`ifdef COMMIT_ENG_VIEW_CHECK_EN
        msg_view_reg   <= msg_view;
`endif
      end
      if (state_reg == CHECK) begin
        target_reg  <= target_calc;
        rd_op_reg   <= state_commit_num + 1'b1;
        wr_op_reg   <= state_commit_num + 1'b1;
        done_op_reg <= state_commit_num;
      end
      if (req_fire) rd_op_reg <= rd_op_reg + 1'b1;
      if (good_fire) begin
        done_op_reg <= wr_op_reg;
        wr_op_reg   <= wr_op_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_eng_pipe.sv
// Directed bench for commit_eng_pipe: a latency-configurable in-order log memory plus a
// scoreboard of expected log writes and state writes, filled when each message is issued.
module tb_commit_eng_pipe;

  localparam int OW = 64, LW = 10, EW = 128, MO = 4, VW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          msg_val, msg_rdy;
  logic [VW-1:0] msg_view, state_view;
  logic [OW-1:0] msg_commit_num, state_commit_num, state_last_op, state_wr_commit_num;
  logic          state_wr_val, state_wr_rdy;
  logic          rd_req_val, rd_req_rdy, rd_resp_val, rd_resp_rdy, wr_val, wr_rdy;
  logic [LW-1:0] rd_req_addr, wr_addr;
  logic [EW-1:0] rd_resp_data, wr_data;
  logic          commit_eng_rdy, drop_pulse;

  commit_eng_pipe #(.OP_NUM_W(OW), .LOG_DEPTH_LOG2(LW), .ENTRY_W(EW),
                    .MAX_OUTSTANDING(MO), .VIEW_W(VW)) dut (
    .clk(clk), .rst(rst), .msg_val(msg_val), .msg_rdy(msg_rdy), .msg_view(msg_view),
    .msg_commit_num(msg_commit_num), .state_view(state_view),
    .state_commit_num(state_commit_num), .state_last_op(state_last_op),
    .state_wr_val(state_wr_val), .state_wr_rdy(state_wr_rdy),
    .state_wr_commit_num(state_wr_commit_num), .rd_req_val(rd_req_val),
    .rd_req_rdy(rd_req_rdy), .rd_req_addr(rd_req_addr), .rd_resp_val(rd_resp_val),
    .rd_resp_rdy(rd_resp_rdy), .rd_resp_data(rd_resp_data), .wr_val(wr_val),
    .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_eng_rdy(commit_eng_rdy), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {logic [LW-1:0] addr; int rdy;} pend_t;
  typedef struct {logic [LW-1:0] addr; logic [EW-1:0] data;} wexp_t;

  localparam logic [EW-1:0] CMASK = {2'b01, 126'd0};

  logic [EW-1:0] mem [1024];
  pend_t         pend[$];
  wexp_t         exp_wr[$];
  logic [OW-1:0] exp_state[$];
  int            tests = 0, failed = 0;
  int            cyc = 0, lat = 1, rd_cnt = 0, outst_tb = 0, max_outst = 0, drop_cnt = 0;
  bit            stall = 0, sw_hold = 0;
  logic [OW-1:0] sw_held;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] entry(input logic [OW-1:0] op);
    return {1'b1, 1'b0, 62'(op * 7 + 3), op};
  endfunction

  // Memory model and write/state scoreboards.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      outst_tb = 0;
      sw_hold  = 0;
    end else begin
      if (rd_resp_val && rd_resp_rdy) begin
        void'(pend.pop_front());
        outst_tb--;
      end
      if (rd_req_val && rd_req_rdy) begin
        pend.push_back('{rd_req_addr, cyc + lat});
        outst_tb++;
        rd_cnt++;
      end
      if (outst_tb > max_outst) max_outst = outst_tb;
      if (wr_val && wr_rdy) begin
        $display("[TB] log write addr=%0d op=%0d", wr_addr, wr_data[OW-1:0]);
        chk("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          chk("wr_addr", wr_addr, exp_wr[0].addr);
          chk("wr_data", wr_data, exp_wr[0].data);
          void'(exp_wr.pop_front());
        end
        mem[wr_addr] = wr_data;
      end
      if (sw_hold) begin
        chk("state_wr_hold_val", state_wr_val, 1);
        chk("state_wr_hold_num", state_wr_commit_num, sw_held);
      end
      sw_hold = 0;
      if (state_wr_val) begin
        if (state_wr_rdy) begin
          $display("[TB] state write commit_num=%0d", state_wr_commit_num);
          chk("state_wr_expected", exp_state.size() > 0, 1);
          if (exp_state.size() > 0) begin
            chk("state_wr_num", state_wr_commit_num, exp_state[0]);
            void'(exp_state.pop_front());
          end
        end else begin
          sw_hold = 1;
          sw_held = state_wr_commit_num;
        end
      end
      if (drop_pulse) drop_cnt++;
    end
    cyc++;
    #1;
    rd_resp_val  = (pend.size() > 0) && (pend[0].rdy <= cyc);
    rd_resp_data = rd_resp_val ? mem[pend[0].addr] : '0;
    rd_req_rdy   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    wr_rdy       = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    state_wr_rdy = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
  end

  task automatic fill(input logic [OW-1:0] lo, input logic [OW-1:0] hi);
    for (logic [OW-1:0] op = lo; op <= hi; op++) mem[op[LW-1:0]] = entry(op);
  endtask

  task automatic expect_writes(input logic [OW-1:0] lo, input logic [OW-1:0] hi);
    for (logic [OW-1:0] op = lo; op <= hi; op++)
      exp_wr.push_back('{op[LW-1:0], entry(op) | CMASK});
  endtask

  // Returns positioned in the CHECK cycle (2 time units after the accepting edge).
  task automatic start_msg(input logic [OW-1:0] sc, input logic [OW-1:0] last,
                           input logic [OW-1:0] mcn, input logic [VW-1:0] mv,
                           input logic [VW-1:0] sv, input int l, input bit st);
    int n = 0;
    lat = l; stall = st;
    state_commit_num = sc; state_last_op = last; state_view = sv;
    msg_view = mv; msg_commit_num = mcn; msg_val = 1'b1;
    $display("[TB] msg commit=%0d state_commit=%0d last_op=%0d", mcn, sc, last);
    while (!msg_rdy && n < 50) begin @(posedge clk); #2; n++; end
    chk("msg_rdy", msg_rdy, 1);
    @(posedge clk); #2;
    msg_val = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_state.size() != 0 || exp_wr.size() != 0 || !commit_eng_rdy) && n < budget) begin
      @(posedge clk); #2; n++;
    end
    chk({tag, "_timeout"}, n < budget, 1);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_pend_left"}, pend.size(), 0);
    chk({tag, "_outst"}, outst_tb, 0);
  endtask

  initial begin
    int snap;
    rst = 1'b1; msg_val = 1'b0; msg_view = '0; msg_commit_num = '0;
    state_view = '0; state_commit_num = '0; state_last_op = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_msg_rdy", msg_rdy, 1);
    chk("rst_eng_rdy", commit_eng_rdy, 1);
    chk("rst_rd_req_val", rd_req_val, 0);
    chk("rst_rd_resp_rdy", rd_resp_rdy, 0);
    chk("rst_wr_val", wr_val, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_state_wr_val", state_wr_val, 0);
    chk("rst_drop", drop_pulse, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Basic commit 6..9, latency 1, with first-request latency check.
    fill(6, 9); expect_writes(6, 9); exp_state.push_back(9);
    start_msg(5, 9, 9, 0, 0, 1, 0);
    chk("t1_check_no_req", rd_req_val, 0);
    chk("t1_check_no_drop", drop_pulse, 0);
    @(posedge clk); #2;
    chk("t1_first_req", rd_req_val, 1);
    chk("t1_first_addr", rd_req_addr, 6);
    wait_done("t1", 200);

    // Target clamped to last_op.
    fill(11, 12); expect_writes(11, 12); exp_state.push_back(12);
    start_msg(10, 12, 20, 0, 0, 2, 0);
    wait_done("t2", 200);

    // Stale commit number dropped.
    snap = rd_cnt;
    start_msg(5, 9, 4, 0, 0, 1, 0);
    chk("t3_drop_pulse", drop_pulse, 1);
    @(posedge clk); #2;
    chk("t3_idle", commit_eng_rdy, 1);
    chk("t3_drop_once", drop_pulse, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("t3_no_reads", rd_cnt - snap, 0);

    // Invalid entry at op 8 stops the walk; outstanding responses drained.
    fill(6, 10); mem[8] = entry(8) & ~{1'b1, 127'd0};
    expect_writes(6, 7); exp_state.push_back(7);
    start_msg(5, 10, 10, 0, 0, 3, 0);
    wait_done("t4", 200);

    // First entry bad: nothing committed, so no state write.
    fill(31, 33); mem[31] = entry(32);
    snap = drop_cnt;
    start_msg(30, 33, 33, 0, 0, 2, 0);
    wait_done("t5", 200);
    repeat (3) @(posedge clk);
    #2;
    chk("t5_idle", commit_eng_rdy, 1);

    // Random stalls, latency 6: outstanding bound and strict order.
    max_outst = 0;
    fill(101, 130); expect_writes(101, 130); exp_state.push_back(130);
    start_msg(100, 200, 130, 0, 0, 6, 1);
    wait_done("t6", 3000);
    chk("t6_max_outst", max_outst <= MO, 1);
    chk("t6_outst_used", max_outst >= 2, 1);
    stall = 0;

    // Address wrap around the log depth.
    fill(1022, 1026); expect_writes(1022, 1026); exp_state.push_back(1026);
    start_msg(1021, 1026, 2000, 0, 0, 2, 0);
    wait_done("t7", 200);

    // View mismatch: dropped only when the view check is built in.
    snap = rd_cnt;
    fill(21, 25);
`ifdef COMMIT_ENG_VIEW_CHECK_EN
    start_msg(20, 25, 25, 3, 4, 1, 0);
    chk("t8_view_drop", drop_pulse, 1);
    repeat (4) @(posedge clk);
    #2;
    chk("t8_no_reads", rd_cnt - snap, 0);
`else
    expect_writes(21, 25); exp_state.push_back(25);
    start_msg(20, 25, 25, 3, 4, 1, 0);
    chk("t8_no_drop", drop_pulse, 0);
    wait_done("t8", 200);
    chk("t8_reads", rd_cnt - snap, 5);
`endif

    chk("final_state_left", exp_state.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
